// File: rtl/mem_lane_if.sv
// Bundle of pipeline request, data-memory port and response signals for mem_lane_unit.
// The unit uses the slave view; the pipeline/memory environment drives the master view.
interface mem_lane_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_byteen;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, dm_ack, dm_rdata,
        input  req_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_byteen,
               rsp_valid, rsp_data, exc_adel, exc_ades, exc_bus
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, dm_ack, dm_rdata,
        output req_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_byteen,
               rsp_valid, rsp_data, exc_adel, exc_ades, exc_bus
    );
endinterface

// File: rtl/mem_lane_unit.sv
// Memory-stage load/store lane unit: word-aligned DM transactions with byte enables and load extension.
// Optional misalignment detection is enabled by defining MEM_LANE_ALIGN_CHECK_EN.
module mem_lane_unit #(
    parameter int MAX_WAIT = 15
) (
    input logic       clk,
    input logic       reset,
    mem_lane_if.slave bus
);
    localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                           OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6;
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_reg;
    logic        ready_reg;
    logic [2:0]  op_reg;
    logic [1:0]  lane_reg;
    logic [7:0]  wait_cnt_reg;
    logic        dm_req_reg, dm_we_reg;
    logic [31:0] dm_addr_reg, dm_wdata_reg;
    logic [3:0]  dm_byteen_reg;
    logic        rsp_valid_reg, adel_reg, ades_reg, bus_err_reg;
    logic [31:0] rsp_data_reg;

    // Request decode for the op presented in the current cycle
    logic [1:0]  req_lane;
    logic        is_store, is_word, is_half, misaligned;
    logic [3:0]  req_byteen;
    logic [31:0] req_lane_wdata;

    assign req_lane = bus.req_addr[1:0];
    assign is_store = (bus.req_op >= OP_SW);
    assign is_word  = (bus.req_op == OP_LW) || (bus.req_op == OP_SW);
    assign is_half  = (bus.req_op == OP_LH) || (bus.req_op == OP_LHU) || (bus.req_op == OP_SH);

`ifdef MEM_LANE_ALIGN_CHECK_EN
    assign misaligned = (is_word && (req_lane != 2'b00)) || (is_half && req_lane[0]);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        req_byteen     = 4'b0000;
        req_lane_wdata = 32'd0;
        if (is_store) begin
            if (is_word) begin
                req_byteen     = 4'b1111;
                req_lane_wdata = bus.req_wdata;
            end else if (is_half) begin
                req_byteen     = req_lane[1] ? 4'b1100 : 4'b0011;
                req_lane_wdata = {2{bus.req_wdata[15:0]}};
            end else begin
                req_byteen     = 4'b0001 << req_lane;
                req_lane_wdata = {4{bus.req_wdata[7:0]}};
            end
        end
    end

    // Read lane slicing of the returned word
    logic [7:0]  rd_byte [4];
    logic [15:0] rd_half [2];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign rd_byte[gi] = bus.dm_rdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign rd_half[gi] = bus.dm_rdata[16*gi +: 16];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    assign sel_byte = rd_byte[lane_reg];
    assign sel_half = rd_half[lane_reg[1]];

    always_comb begin
        load_ext = 32'd0;
        case (op_reg)
            OP_LW:   load_ext = bus.dm_rdata;
            OP_LH:   load_ext = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_ext = {16'd0, sel_half};
            OP_LB:   load_ext = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_ext = {24'd0, sel_byte};
            default: load_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
            op_reg        <= 3'd0;
            lane_reg      <= 2'd0;
            wait_cnt_reg  <= 8'd0;
            dm_req_reg    <= 1'b0;
            dm_we_reg     <= 1'b0;
            dm_addr_reg   <= 32'd0;
            dm_wdata_reg  <= 32'd0;
            dm_byteen_reg <= 4'd0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 32'd0;
            adel_reg      <= 1'b0;
            ades_reg      <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 32'd0;
            adel_reg      <= 1'b0;
            ades_reg      <= 1'b0;
            bus_err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (misaligned) begin
                            rsp_valid_reg <= 1'b1;
                            adel_reg      <= ~is_store;
                            ades_reg      <= is_store;
                        end else begin
                            state_reg     <= BUSY;
                            ready_reg     <= 1'b0;
                            op_reg        <= bus.req_op;
                            lane_reg      <= req_lane;
                            wait_cnt_reg  <= 8'd0;
                            dm_req_reg    <= 1'b1;
                            dm_we_reg     <= is_store;
                            dm_addr_reg   <= {bus.req_addr[31:2], 2'b00};
                            dm_wdata_reg  <= req_lane_wdata;
                            dm_byteen_reg <= req_byteen;
                        end
                    end
                end
                BUSY: begin
                    // An ack on the final wait cycle still completes normally
                    if (bus.dm_ack || (wait_cnt_reg == MAX_WAIT_C)) begin
                        state_reg     <= IDLE;
                        ready_reg     <= 1'b1;
                        dm_req_reg    <= 1'b0;
                        dm_we_reg     <= 1'b0;
                        dm_addr_reg   <= 32'd0;
                        dm_wdata_reg  <= 32'd0;
                        dm_byteen_reg <= 4'd0;
                        rsp_valid_reg <= 1'b1;
                        bus_err_reg   <= ~bus.dm_ack;
                        rsp_data_reg  <= (bus.dm_ack && !dm_we_reg) ? load_ext : 32'd0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_reg;
    assign bus.dm_req    = dm_req_reg;
    assign bus.dm_we     = dm_we_reg;
    assign bus.dm_addr   = dm_addr_reg;
    assign bus.dm_wdata  = dm_wdata_reg;
    assign bus.dm_byteen = dm_byteen_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.exc_adel  = adel_reg;
    assign bus.exc_ades  = ades_reg;
    assign bus.exc_bus   = bus_err_reg;
endmodule
